// File: rtl/bfp_bw_tracker.sv
// Block-floating-point bit-width tracker: reports the widest signed word seen over a 2^FFT_N sample block.
// Optional BFP_FULLSCALE_FLAG_EN adds a fullscale flag for blocks containing the most-negative value.
module bfp_bw_tracker #(
    parameter int FFT_DW    = 16,
    parameter int FFT_BFPDW = 5,
    parameter int FFT_N     = 10
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        din_valid,
    input  logic signed [FFT_DW-1:0]    din_re,
    input  logic signed [FFT_DW-1:0]    din_im,
    output logic                        busy,
    output logic                        bw_valid,
    output logic        [FFT_BFPDW-1:0] bw
`ifdef BFP_FULLSCALE_FLAG_EN
    ,
    output logic                        fullscale
`endif
);

    localparam logic [FFT_DW-1:0] MOST_NEG = {1'b1, {(FFT_DW-1){1'b0}}};

    function automatic logic [FFT_BFPDW-1:0] word_width(input logic signed [FFT_DW-1:0] x);
        logic [FFT_DW-1:0]    y;
        logic [FFT_BFPDW-1:0] w;
        w = '0;
        // Negative values are measured on their complement so that -1 maps to 0 like 0 does
        y = x[FFT_DW-1] ? ~x : x;
        for (int i = 0; i < FFT_DW; i++) begin
            if (y[i]) w = FFT_BFPDW'(i + 1);
        end
        if (x == MOST_NEG) w = FFT_BFPDW'(FFT_DW);
        return w;
    endfunction

    function automatic logic [FFT_BFPDW-1:0] umax(input logic [FFT_BFPDW-1:0] a,
                                                  input logic [FFT_BFPDW-1:0] b);
        return (a > b) ? a : b;
    endfunction

    logic [FFT_N-1:0]     r_cnt;
    logic                 r_busy;
    logic                 r_vld_p1;
    logic                 r_last_p1;
    logic [FFT_BFPDW-1:0] r_s1_p1;
    logic                 r_bwv_p2;
    logic [FFT_BFPDW-1:0] r_acc_p2;
    logic [FFT_BFPDW-1:0] r_bw_p2;

    logic                 w_accept;
    logic [FFT_N-1:0]     w_cnt_cur;
    logic                 w_last;
    logic                 w_abort;
    logic                 w_done;
    logic [FFT_BFPDW-1:0] w_s1;
    logic [FFT_BFPDW-1:0] w_acc_max;

    assign w_accept  = din_valid && (r_busy || start);
    assign w_cnt_cur = start ? '0 : r_cnt;
    assign w_last    = w_accept && (w_cnt_cur == {FFT_N{1'b1}});
    assign w_abort   = start && r_busy;
    assign w_s1      = umax(word_width(din_re), word_width(din_im));
    assign w_acc_max = umax(r_acc_p2, r_s1_p1);
    assign w_done    = r_vld_p1 && r_last_p1 && !w_abort;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_vld_p1  <= 1'b0;
            r_last_p1 <= 1'b0;
            r_bwv_p2  <= 1'b0;
        end else begin
            if (w_accept)   r_cnt <= w_cnt_cur + 1'b1;
            else if (start) r_cnt <= '0;
            if (w_last)     r_busy <= 1'b0;
            else if (start) r_busy <= 1'b1;
            r_vld_p1  <= w_accept;
            r_last_p1 <= w_last;
            r_bwv_p2  <= w_done;
        end
    end

    // Stage 1: per-sample width
    always_ff @(posedge clk) begin
        r_s1_p1 <= w_s1;
    end

    // Stage 2: running maximum; a start drops whatever stage 1 holds from an aborted block
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc_p2 <= '0;
            r_bw_p2  <= '0;
        end else begin
            if (start)         r_acc_p2 <= '0;
            else if (r_vld_p1) r_acc_p2 <= w_acc_max;
            if (w_done)        r_bw_p2  <= w_acc_max;
        end
    end

    assign busy     = r_busy;
    assign bw_valid = r_bwv_p2;
    assign bw       = r_bw_p2;

`ifdef BFP_FULLSCALE_FLAG_EN
    logic r_fs_p1;
    logic r_fsacc_p2;
    logic r_fs_p2;
    logic w_fs;

    assign w_fs = (din_re == MOST_NEG) || (din_im == MOST_NEG);

    always_ff @(posedge clk) begin
        r_fs_p1 <= w_fs;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsacc_p2 <= 1'b0;
            r_fs_p2    <= 1'b0;
        end else begin
            if (start)         r_fsacc_p2 <= 1'b0;
            else if (r_vld_p1) r_fsacc_p2 <= r_fsacc_p2 | r_fs_p1;
            if (w_done)        r_fs_p2    <= r_fsacc_p2 | r_fs_p1;
        end
    end

    assign fullscale = r_fs_p2;
`endif

endmodule

// File: tb/tb_bfp_bw_tracker.sv
// Directed bench for bfp_bw_tracker with FFT_DW=16, FFT_BFPDW=5, FFT_N=4 (16-sample blocks).
module tb_bfp_bw_tracker;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        din_valid;
    logic [15:0] din_re;
    logic [15:0] din_im;
    logic        busy;
    logic        bw_valid;
    logic [4:0]  bw;
`ifdef BFP_FULLSCALE_FLAG_EN
    logic        fullscale;
`endif

    int n_assert = 0;
    int n_fail   = 0;
    int n_bwv    = 0;
    int n0;

    logic [15:0] re_v [16];
    logic [15:0] im_v [16];

    bfp_bw_tracker #(.FFT_DW(16), .FFT_BFPDW(5), .FFT_N(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .din_valid (din_valid),
        .din_re    (din_re),
        .din_im    (din_im),
        .busy      (busy),
        .bw_valid  (bw_valid),
        .bw        (bw)
`ifdef BFP_FULLSCALE_FLAG_EN
        ,
        .fullscale (fullscale)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bw_valid) n_bwv <= n_bwv + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic s, input logic v, input logic [15:0] re, input logic [15:0] im);
        start     = s;
        din_valid = v;
        din_re    = re;
        din_im    = im;
        @(posedge clk);
        #1;
        start     = 1'b0;
        din_valid = 1'b0;
    endtask

    task automatic fill(input logic [15:0] v);
        for (int i = 0; i < 16; i++) begin
            re_v[i] = v;
            im_v[i] = v;
        end
    endtask

    task automatic run_block(input string tag, input logic [4:0] exp_bw, input logic exp_fs,
                             input int gap_at, input logic chain);
        for (int i = 0; i < 16; i++) begin
            if (i == gap_at) begin
                for (int g = 0; g < 3; g++) cyc(1'b0, 1'b0, 16'h7fff, 16'h7fff);
                chk({tag, "_busy_gap"}, 32'(busy), 32'd1);
            end
            cyc(i == 0, 1'b1, re_v[i], im_v[i]);
            if (i == 0) begin
                chk({tag, "_busy_first"}, 32'(busy), 32'd1);
                chk({tag, "_bwv_first"}, 32'(bw_valid), 32'd0);
            end
        end
        chk({tag, "_busy_end"}, 32'(busy), 32'd0);
        chk({tag, "_bwv_early"}, 32'(bw_valid), 32'd0);
        cyc(1'b0, 1'b0, 16'h0000, 16'h0000);
        chk({tag, "_bwv"}, 32'(bw_valid), 32'd1);
        chk({tag, "_bw"}, 32'(bw), 32'(exp_bw));
`ifdef BFP_FULLSCALE_FLAG_EN
        chk({tag, "_fs"}, 32'(fullscale), 32'(exp_fs));
`else
        if (exp_fs) chk({tag, "_fs_nomacro_bw"}, 32'(bw), 32'd16);
`endif
        if (!chain) begin
            cyc(1'b0, 1'b0, 16'h0000, 16'h0000);
            chk({tag, "_bwv_off"}, 32'(bw_valid), 32'd0);
            chk({tag, "_bw_hold"}, 32'(bw), 32'(exp_bw));
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; din_valid = 1'b0; din_re = '0; din_im = '0;
        // Reset with start/din_valid asserted: both must be ignored
        cyc(1'b1, 1'b1, 16'h4000, 16'h4000);
        cyc(1'b1, 1'b1, 16'h4000, 16'h4000);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_bwv", 32'(bw_valid), 32'd0);
        chk("rst_bw", 32'(bw), 32'd0);
`ifdef BFP_FULLSCALE_FLAG_EN
        chk("rst_fs", 32'(fullscale), 32'd0);
`endif
        rst = 1'b0;
        cyc(1'b0, 1'b0, 16'h0000, 16'h0000);
        chk("post_rst_busy", 32'(busy), 32'd0);

        fill(16'h0000);
        run_block("zero", 5'd0, 1'b0, -1, 1'b0);

        fill(16'h0001); re_v[7] = 16'h4000;
        run_block("mix_re", 5'd15, 1'b0, -1, 1'b1);
        // Next block starts in the same cycle bw_valid is high
        fill(16'h0001); im_v[7] = 16'hC000;
        run_block("mix_im", 5'd14, 1'b0, -1, 1'b0);

        fill(16'hFFFE);
        run_block("neg_small", 5'd1, 1'b0, -1, 1'b0);

        fill(16'h0001); re_v[3] = 16'h8000;
        run_block("fullscale", 5'd16, 1'b1, -1, 1'b0);

        fill(16'h0001); re_v[7] = 16'h4000;
        run_block("no_fullscale", 5'd15, 1'b0, -1, 1'b0);

        n0 = n_bwv;
        for (int i = 0; i < 9; i++) cyc(i == 0, 1'b1, 16'h4000, 16'h0001);
        chk("abort_busy", 32'(busy), 32'd1);
        fill(16'h0003);
        run_block("abort", 5'd2, 1'b0, -1, 1'b0);
        chk("abort_pulses", 32'(n_bwv - n0), 32'd1);

        fill(16'h0004);
        run_block("gap", 5'd3, 1'b0, 8, 1'b0);

        n0 = n_bwv;
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 16'h4000, 16'h8000);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_bw", 32'(bw), 32'd3);
        chk("idle_pulses", 32'(n_bwv - n0), 32'd0);

        n0 = n_bwv;
        for (int i = 0; i < 5; i++) cyc(i == 0, 1'b1, 16'h4000, 16'h4000);
        rst = 1'b1;
        cyc(1'b1, 1'b1, 16'h8000, 16'h8000);
        rst = 1'b0;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_bw", 32'(bw), 32'd0);
        chk("midrst_bwv", 32'(bw_valid), 32'd0);
        for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, 16'h4000, 16'h4000);
        chk("midrst_pulses", 32'(n_bwv - n0), 32'd0);
        chk("midrst_busy_later", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
